// File: rtl/serial_logic_seq_pkg.sv
// Shared definitions for the bit-serial logic sequencer: opcodes, FSM states
// and the single-bit logic function evaluated by the logicunit slice.
package serial_logic_seq_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  function automatic logic lu_eval(input logic a, input logic b, input logic [1:0] op);
    logic y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/serial_logic_seq_logicunit.sv
// 1-bit logic slice: produces one result bit per cycle from one bit of each
// operand and the 2-bit op select.
module logicunit
  import serial_logic_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] control,
  output logic       y
);

  // Pure combinational evaluation of the selected logic function
  always_comb begin
    y = lu_eval(a, b, control);
  end

endmodule

// File: rtl/serial_logic_seq.sv
// Bit-serial sequencer: accepts two operands, streams them LSB-first through
// one logicunit slice and presents the reassembled word with a zero flag.
module serial_logic_seq
  import serial_logic_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic [WIDTH-1:0] res_next_s;
  logic [1:0]       op_r;
  logic             lu_y_s;
  logic             accept_s;
  logic             last_s;

  logicunit u_lu (
    .a       (a_sh_r[0]),
    .b       (b_sh_r[0]),
    .control (op_r),
    .y       (lu_y_s)
  );

  // Next-state decode and control strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          state_s  = S_SHIFT;
          accept_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_r == LAST_CNT) begin
          state_s = S_DONE;
          last_s  = 1'b1;
        end else begin
          state_s = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Result shifter: new bit enters at the MSB so the LSB-first stream lands in place
  always_comb begin
    res_next_s            = res_sh_r >> 1;
    res_next_s[WIDTH-1]   = lu_y_s;
  end

  // State register and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == S_IDLE);
      out_valid <= (state_s == S_DONE);
      busy      <= (state_s == S_SHIFT) || (state_s == S_DONE);
    end
  end

  // Operand capture, serial shifting, bit counter and result load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      op_r     <= OP_AND;
      result   <= '0;
    end else begin
      if (accept_s) begin
        a_sh_r   <= a;
        b_sh_r   <= b;
        op_r     <= control;
        cnt_r    <= '0;
        res_sh_r <= '0;
      end else if (state_r == S_SHIFT) begin
        a_sh_r   <= a_sh_r >> 1;
        b_sh_r   <= b_sh_r >> 1;
        res_sh_r <= res_next_s;
        cnt_r    <= cnt_r + CNT_W'(1);
        if (last_s) begin
          result <= res_next_s;
        end
      end
    end
  end

  assign zero = ~|result;

endmodule

// File: tb/tb_serial_logic_seq.sv
// Directed self-checking bench for serial_logic_seq with hand-computed results.
module tb_serial_logic_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  serial_logic_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1ns past it before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation; out_ready held low for hold cycles in DONE, then released
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [1:0] ctl, input logic [7:0] exp, input int hold);
    check_eq({tag, ".in_ready"}, in_ready, 1);
    a = ta; b = tb_; control = ctl; in_valid = 1'b1; out_ready = 1'b0;
    step();  // edge 0: accept
    in_valid = 1'b0; a = ~ta; b = ~tb_; control = ~ctl;
    check_eq({tag, ".busy"}, busy, 1);
    check_eq({tag, ".in_ready_shift"}, in_ready, 0);
    for (int i = 1; i < WIDTH; i++) step();
    check_eq({tag, ".early_valid"}, out_valid, 0);
    step();  // edge WIDTH
    check_eq({tag, ".out_valid"}, out_valid, 1);
    check_eq({tag, ".result"}, result, exp);
    check_eq({tag, ".zero"}, zero, (exp == 8'h00) ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq({tag, ".hold_valid"}, out_valid, 1);
      check_eq({tag, ".hold_result"}, result, exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, ".post_valid"}, out_valid, 0);
    check_eq({tag, ".post_in_ready"}, in_ready, 1);
    check_eq({tag, ".post_busy"}, busy, 0);
    check_eq({tag, ".retained"}, result, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; control = 2'b00; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check_eq("rst.in_ready", in_ready, 1);
    check_eq("rst.out_valid", out_valid, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.result", result, 0);
    check_eq("rst.zero", zero, 1);

    run_op("and", 8'hF0, 8'h3C, 2'b00, 8'h30, 5);
    run_op("nor", 8'h00, 8'h00, 2'b10, 8'hFF, 0);
    run_op("xor", 8'hAA, 8'hAA, 2'b11, 8'h00, 1);
    run_op("or",  8'h81, 8'h18, 2'b01, 8'h99, 0);

    // in_valid during SHIFT with different operands must be ignored
    a = 8'h0F; b = 8'h33; control = 2'b00; in_valid = 1'b1;
    step();
    a = 8'hFF; b = 8'hFF; control = 2'b01;
    for (int i = 1; i < WIDTH; i++) step();
    in_valid = 1'b0;
    step();
    check_eq("ign.out_valid", out_valid, 1);
    check_eq("ign.result", result, 8'h03);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("ign.in_ready", in_ready, 1);

    // Reset at counter = 3 discards the operation
    a = 8'hFF; b = 8'hFF; control = 2'b01; in_valid = 1'b1;
    step();  // edge 0
    in_valid = 1'b0;
    step(); step(); step();  // counter now 3
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("mrst.in_ready", in_ready, 1);
    check_eq("mrst.busy", busy, 0);
    check_eq("mrst.result", result, 0);
    check_eq("mrst.zero", zero, 1);
    for (int i = 0; i < WIDTH + 2; i++) begin
      step();
      check_eq("mrst.no_valid", out_valid, 0);
    end

    run_op("after_rst", 8'hC3, 8'h5A, 2'b11, 8'h99, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
